yakbd_ps2_rx: RTL and testbench

- Front end of the yakbd keyboard path. Samples the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames.
- Decodes the E0 (extended) and F0 (break) prefixes and tracks the Shift and Ctrl modifier state.
- Queues make-code events in a small FIFO. Each FIFO head presents {pscode, shift, ctrl} in the form the downstream scan-code-to-ASCII translator consumes, with a valid/ready handshake.

---
 rtl/yakbd_ps2_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_yakbd_ps2_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/yakbd_ps2_rx.sv
// yakbd PS/2 receiver: line sync, frame deserialiser,
// prefix decoder, modifier tracking and event FIFO.
module yakbd_ps2_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [7:0] pscode,
  output logic       shift,
  output logic       ctrl,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] C_TMO  = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    RX_IDLE, RX_DATA, RX_PAR, RX_STOP
  } rx_t;

  typedef enum logic [1:0] {
    DC_BASE, DC_EXT, DC_BRK, DC_EBRK
  } dc_t;

  logic          r_ck1, r_ck2, r_ck3;
  logic          r_dt1, r_dt2;
  logic          w_fall, w_bit;
  logic [TW-1:0] r_idle;
  logic          w_tmo;
  rx_t           r_rx, w_rx_nxt;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bcnt;
  logic          r_par;
  logic          w_good, w_stb, w_err;
  logic          r_stb, r_ferr;
  logic [7:0]    r_byte;
  dc_t           r_dc, w_dc_nxt;
  logic          w_ign, w_e0, w_f0;
  logic          w_evt, w_ext, w_brk;
  logic          r_lsh, r_rsh, r_lct, r_rct;
  logic          w_mod, w_push;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_pop, w_wr;
  logic          r_ovf;
  logic [9:0]    w_head;

  // Resynchronise both lines; idle level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ck1 <= 1'b1; r_ck2 <= 1'b1; r_ck3 <= 1'b1;
      r_dt1 <= 1'b1; r_dt2 <= 1'b1;
    end else begin
      r_ck1 <= ps2_clk; r_ck2 <= r_ck1; r_ck3 <= r_ck2;
      r_dt1 <= ps2_data; r_dt2 <= r_dt1;
    end
  end

  // PS/2 clock went high-to-low: sample data now
  assign w_fall = r_ck3 & ~r_ck2;
  assign w_bit  = r_dt2;

  // Cycles since the last PS/2 clock edge, saturating
  always_ff @(posedge clk) begin
    if (rst || w_fall) r_idle <= '0;
    else if (r_idle != C_TMO) r_idle <= r_idle + TW'(1);
  end

  assign w_tmo = (r_rx != RX_IDLE) &&
                 (r_idle == C_TMO) && !w_fall;

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) r_rx <= RX_IDLE;
    else     r_rx <= w_rx_nxt;
  end

  // Receiver next state; a stalled frame is abandoned
  always_comb begin
    w_rx_nxt = r_rx;
    if (w_tmo) w_rx_nxt = RX_IDLE;
    else if (w_fall) begin
      case (r_rx)
        RX_IDLE: if (!w_bit) w_rx_nxt = RX_DATA;
        RX_DATA: if (r_bcnt == 3'd7) w_rx_nxt = RX_PAR;
        RX_PAR:  w_rx_nxt = RX_STOP;
        default: w_rx_nxt = RX_IDLE;
      endcase
    end
  end

  // Receiver outputs: good byte strobe or frame error
  always_comb begin
    w_good = w_bit & (^r_shreg ^ r_par);
    w_stb  = (r_rx == RX_STOP) & w_fall & w_good;
    w_err  = w_tmo |
             ((r_rx == RX_STOP) & w_fall & ~w_good);
  end

  // Shift register, bit counter and parity capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_bcnt  <= '0;
      r_par   <= 1'b0;
    end else if (w_fall) begin
      case (r_rx)
        RX_IDLE: r_bcnt <= '0;
        RX_DATA: begin
          r_shreg <= {w_bit, r_shreg[7:1]};
          r_bcnt  <= r_bcnt + 3'd1;
        end
        RX_PAR:  r_par <= w_bit;
        default: ;
      endcase
    end
  end

  // Register the byte strobe and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stb  <= 1'b0;
      r_ferr <= 1'b0;
      r_byte <= '0;
    end else begin
      r_stb  <= w_stb;
      r_ferr <= w_err;
      if (w_stb) r_byte <= r_shreg;
    end
  end

  assign w_ign = r_byte inside {8'hE1, 8'hAA,
                 8'hFA, 8'hEE, 8'hFC, 8'hFE,
                 8'h00, 8'hFF};
  assign w_e0  = (r_byte == 8'hE0);
  assign w_f0  = (r_byte == 8'hF0);

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) r_dc <= DC_BASE;
    else     r_dc <= w_dc_nxt;
  end

  // Decoder next state: prefixes accumulate, codes end
  always_comb begin
    w_dc_nxt = r_dc;
    if (r_stb && !w_ign) begin
      if (w_e0) begin
        if (r_dc == DC_BASE) w_dc_nxt = DC_EXT;
      end else if (w_f0) begin
        if (r_dc == DC_BASE) w_dc_nxt = DC_BRK;
        if (r_dc == DC_EXT)  w_dc_nxt = DC_EBRK;
      end else begin
        w_dc_nxt = DC_BASE;
      end
    end
  end

  // Decoder outputs: completed event and its flavour
  always_comb begin
    w_evt = r_stb & ~w_ign & ~w_e0 & ~w_f0;
    w_ext = (r_dc == DC_EXT) | (r_dc == DC_EBRK);
    w_brk = (r_dc == DC_BRK) | (r_dc == DC_EBRK);
  end

  // Modifier flags: make sets, break clears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lsh <= 1'b0; r_rsh <= 1'b0;
      r_lct <= 1'b0; r_rct <= 1'b0;
    end else if (w_evt) begin
      if (r_byte == 8'h12 && !w_ext) r_lsh <= ~w_brk;
      if (r_byte == 8'h59)           r_rsh <= ~w_brk;
      if (r_byte == 8'h14 && !w_ext) r_lct <= ~w_brk;
      if (r_byte == 8'h14 &&  w_ext) r_rct <= ~w_brk;
    end
  end

  // E0 12 (fake shift) also falls in the modifier set
  assign w_mod  = (r_byte == 8'h12) |
                  (r_byte == 8'h59) |
                  (r_byte == 8'h14);
  assign w_push = w_evt & ~w_brk & ~w_mod;

  assign w_full = (r_cnt == C_FULL);
  assign w_pop  = code_valid & code_ready;
  assign w_wr   = w_push & (~w_full | w_pop);

  // Event storage; modifier state rides with each code
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= {r_lct | r_rct,
                      r_lsh | r_rsh, r_byte};
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
      r_ovf <= w_push & w_full & ~w_pop;
    end
  end

  assign w_head     = r_mem[r_rp];
  assign code_valid = (r_cnt != '0);
  assign pscode     = code_valid ? w_head[7:0] : '0;
  assign shift      = code_valid & w_head[8];
  assign ctrl       = code_valid & w_head[9];
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_yakbd_ps2_rx.sv
// Directed bench for yakbd_ps2_rx: frames, prefixes,
// modifiers, errors, timeout, FIFO fill/wrap and reset.
module tb_yakbd_ps2_rx;

  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       code_ready;
  logic       code_valid;
  logic [7:0] pscode;
  logic       shift;
  logic       ctrl;
  logic       frame_err;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;
  int n_ferr = 0;
  int n_ovf = 0;

  yakbd_ps2_rx #(
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code_ready(code_ready),
    .code_valid(code_valid),
    .pscode    (pscode),
    .shift     (shift),
    .ctrl      (ctrl),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overflow)  n_ovf++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag,
                         input logic [7:0] code,
                         input logic s,
                         input logic c);
    int n;
    n = 0;
    while (!code_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, code_valid, 1);
    check({tag, "_code"}, pscode, code);
    check({tag, "_shift"}, shift, s);
    check({tag, "_ctrl"}, ctrl, c);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
  endtask

  task automatic out_zero(input string tag);
    check({tag, "_valid"}, code_valid, 0);
    check({tag, "_code"}, pscode, 0);
    check({tag, "_shift"}, shift, 0);
    check({tag, "_ctrl"}, ctrl, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  logic [7:0] seq9 [9];
  logic [7:0] b;
  int ferr0;
  int ovf0;

  initial begin
    seq9 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
             8'h36, 8'h3D, 8'h3E, 8'h46};
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    code_ready = 1'b0;
    repeat (4) @(negedge clk);
    out_zero("rst_hold");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    out_zero("rst_rel");

    // 1C with exact latency from the stop-bit edge
    b = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("lat_early", code_valid, 0);
    @(negedge clk);
    check("lat_on", code_valid, 1);
    repeat (16) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    pop_chk("f1c", 8'h1C, 0, 0);
    check("f1c_pop", code_valid, 0);

    // Shift make/break around two 1C makes
    send_frame(8'h12, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h12, 0);
    send_frame(8'h1C, 0);
    pop_chk("sh1", 8'h1C, 1, 0);
    pop_chk("sh0", 8'h1C, 0, 0);
    check("sh_empty", code_valid, 0);

    // Right ctrl, extended code, extended break
    send_frame(8'hE0, 0);
    send_frame(8'h14, 0);
    send_frame(8'h21, 0);
    pop_chk("rctl", 8'h21, 0, 1);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    pop_chk("ext75", 8'h75, 0, 1);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check("extbrk_none", code_valid, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h14, 0);
    send_frame(8'h1C, 0);
    pop_chk("rctl_off", 8'h1C, 0, 0);

    // Parity error, then a stalled frame times out
    ferr0 = n_ferr;
    send_frame(8'h1C, 1);
    check("par_err", n_ferr - ferr0, 1);
    check("par_none", code_valid, 0);
    b = 8'h29;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    repeat (TMO - 200) @(negedge clk);
    check("tmo_early", n_ferr - ferr0, 1);
    repeat (400) @(negedge clk);
    check("tmo_err", n_ferr - ferr0, 2);
    send_frame(8'h29, 0);
    pop_chk("after_tmo", 8'h29, 0, 0);
    check("ferr_tot", n_ferr - ferr0, 2);

    // Fill past capacity, drain, then refill across wrap
    ovf0 = n_ovf;
    for (int i = 0; i < 9; i++) begin
      send_frame(seq9[i], 0);
      if (i == 7) check("ovf_none8", n_ovf - ovf0, 0);
    end
    check("ovf_9th", n_ovf - ovf0, 1);
    for (int i = 0; i < 8; i++)
      pop_chk($sformatf("drain%0d", i), seq9[i], 0, 0);
    check("drain_empty", code_valid, 0);
    send_frame(8'h1C, 0);
    send_frame(8'h29, 0);
    pop_chk("wrap0", 8'h1C, 0, 0);
    pop_chk("wrap1", 8'h29, 0, 0);
    check("wrap_empty", code_valid, 0);

    // Reset mid-frame with shift held and FIFO occupied
    send_frame(8'h12, 0);
    send_frame(8'h1C, 0);
    check("pre_rst_valid", code_valid, 1);
    check("pre_rst_shift", shift, 1);
    b = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(b[i]);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    out_zero("mid_rst");
    rst = 1'b0;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    out_zero("post_rst");
    ferr0 = n_ferr;
    send_frame(8'h1C, 0);
    pop_chk("post_rst_1c", 8'h1C, 0, 0);
    check("post_rst_ferr", n_ferr - ferr0, 0);
    check("post_rst_empty", code_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
